// File: rtl/pulse_stretcher_pkg.sv
// Shared types and width helpers for the pulse stretcher.
package pulse_stretcher_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ON   = 1'b1
  } state_t;

  // Width of the remaining-periods counter (must hold 0..duration)
  function automatic int cw_f(input int duration);
    return $clog2(duration + 1);
  endfunction

  // Width of the prescaler count (at least one bit)
  function automatic int pw_f(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/pulse_stretcher_prescale_counter.sv
// Prescaler: counts 0..PRESCALE-1 while enabled and strobes on the last count.
module prescale_counter
  import pulse_stretcher_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic strobe
);

  localparam int PW = pw_f(PRESCALE);

  logic [PW-1:0] cnt;

  assign strobe = en && (cnt == PW'(PRESCALE - 1));

  // Period counter; clear restarts the period from zero
  always_ff @(posedge clock) begin
    if (reset || clear) cnt <= '0;
    else if (en)        cnt <= strobe ? '0 : cnt + PW'(1);
  end

endmodule

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns a one-cycle tick into a level held for
// DURATION x PRESCALE cycles, with cancel, remaining-time readout and an
// expiry strobe. Define PULSE_STRETCHER_RETRIGGER_EN to let a tick during
// the on-time restart it.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int DURATION = 8,
  parameter int PRESCALE = 1,
  localparam int CW      = cw_f(DURATION)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          tick,
  input  logic          cancel,
  output logic          out,
  output logic [CW-1:0] remaining,
  output logic          done
);

  state_t state;
  logic   strobe;
  logic   start;
  logic   retrig;
  logic   expire;
  logic   clear;

  // Decode the events that change the on-time this cycle
  always_comb begin
    start  = (state == IDLE) && tick && !cancel;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    retrig = (state == ON) && tick && !cancel;
`else
    retrig = 1'b0;
`endif
    // A retrigger on the last period beats natural expiry
    expire = (state == ON) && strobe && (remaining == CW'(1)) && !cancel && !retrig;
    clear  = cancel || start || retrig;
  end

  prescale_counter #(
    .PRESCALE (PRESCALE)
  ) u_prescale (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .en     (state == ON),
    .strobe (strobe)
  );

  // FSM, remaining counter and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      out       <= 1'b0;
      remaining <= '0;
      done      <= 1'b0;
    end else if (cancel) begin
      state     <= IDLE;
      out       <= 1'b0;
      remaining <= '0;
      done      <= 1'b0;
    end else if (start || retrig) begin
      state     <= ON;
      out       <= 1'b1;
      remaining <= CW'(DURATION);
      done      <= 1'b0;
    end else if (expire) begin
      state     <= IDLE;
      out       <= 1'b0;
      remaining <= '0;
      done      <= 1'b1;
    end else begin
      done <= 1'b0;
      if ((state == ON) && strobe) remaining <= remaining - CW'(1);
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher (DURATION=4, PRESCALE=2). Each scenario
// builds a per-cycle expectation table from the documented timing, pushes one
// entry to the scoreboard as each cycle is driven and checks it mid-cycle.
module tb_pulse_stretcher;

  localparam int DUR  = 4;
  localparam int PRE  = 2;
  localparam int CW   = $clog2(DUR + 1);
  localparam int NCYC = 40;

  typedef struct {
    bit           vld;
    bit           out;
    int           rem;
    bit           done;
    int           cyc;
  } exp_t;

  logic          clock = 1'b1;
  logic          reset, tick, cancel;
  logic          out, done;
  logic [CW-1:0] remaining;

  int checks = 0;
  int errors = 0;

  bit tk [NCYC], cn [NCYC], rs [NCYC];
  bit e_out [NCYC], e_done [NCYC];
  int e_rem [NCYC];
  exp_t sb [$];
  string name;

  always #5 clock = ~clock;

  pulse_stretcher #(.DURATION(DUR), .PRESCALE(PRE)) dut (
    .clock     (clock),
    .reset     (reset),
    .tick      (tick),
    .cancel    (cancel),
    .out       (out),
    .remaining (remaining),
    .done      (done)
  );

  task automatic blank();
    for (int i = 0; i < NCYC; i++) begin
      tk[i] = 0; cn[i] = 0; rs[i] = 0;
      e_out[i] = 0; e_rem[i] = 0; e_done[i] = 0;
    end
    rs[0] = 1; rs[1] = 1;
  endtask

  // On-time starting in cycle s: DUR periods of PRE cycles, done right after
  task automatic window(input int s);
    for (int i = 0; i < DUR * PRE; i++) begin
      e_out[s+i] = 1; e_rem[s+i] = DUR - i / PRE; e_done[s+i] = 0;
    end
    e_out[s+DUR*PRE] = 0; e_rem[s+DUR*PRE] = 0; e_done[s+DUR*PRE] = 1;
  endtask

  task automatic idle_from(input int c, input int upto);
    for (int i = c; i < upto; i++) begin
      e_out[i] = 0; e_rem[i] = 0; e_done[i] = 0;
    end
  endtask

  task automatic run(input int n);
    exp_t e, g;
    for (int c = 0; c < n; c++) begin
      reset = rs[c]; tick = tk[c]; cancel = cn[c];
      e.vld = (c != 0); e.out = e_out[c]; e.rem = e_rem[c];
      e.done = e_done[c]; e.cyc = c;
      sb.push_back(e);
      @(negedge clock);
      g = sb.pop_front();
      if (g.vld) begin
        checks += 3;
        assert (out === g.out) else begin
          errors++;
          $error("FAIL %s out cyc %0d: got %b want %b", name, g.cyc, out, g.out);
        end
        assert (remaining === CW'(g.rem)) else begin
          errors++;
          $error("FAIL %s remaining cyc %0d: got %0d want %0d", name, g.cyc, remaining, g.rem);
        end
        assert (done === g.done) else begin
          errors++;
          $error("FAIL %s done cyc %0d: got %b want %b", name, g.cyc, done, g.done);
        end
      end
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset = 1; tick = 0; cancel = 0;

    name = "basic";
    blank(); tk[3] = 1; window(4);
    run(16);

    name = "cancel";
    blank(); tk[3] = 1; cn[6] = 1; window(4); idle_from(7, NCYC);
    run(16);

    name = "simul";
    blank(); tk[3] = 1; cn[3] = 1;
    run(10);

    name = "retrig";
    blank(); tk[3] = 1; tk[7] = 1;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    window(4); window(8);
`else
    window(4);
`endif
    run(20);

    name = "held";
    blank();
    for (int i = 3; i <= 14; i++) tk[i] = 1;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    window(4);
    for (int i = 5; i <= 15; i++) window(i);
`else
    window(4); window(13);
`endif
    run(26);

    name = "midreset";
    blank(); tk[3] = 1; rs[8] = 1; window(4); idle_from(9, NCYC);
    tk[12] = 1; window(13);
    run(25);

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard residue: got %0d entries want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
